nlm_norm_div: RTL and testbench

Normalisation stage that consumes the accumulated pixel and weight sums emitted by the last PE of the denoise weighting chain and produces the filtered output pixel, round(pix_sum / weight_sum). It uses an iterative radix-2 restoring divider with valid/ready handshakes on both sides, holding one result at a time. Zero-weight and overflow cases are resolved in this block, so downstream logic always receives a legal DATA_WIDTH pixel.

---
 rtl/nlm_pkg.sv | 18 +
 rtl/nlm_norm_div_if.sv | 26 ++
 rtl/nlm_div_step.sv | 25 ++
 rtl/nlm_norm_div.sv | 119 +++++++++++
 tb/tb_nlm_norm_div.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/nlm_pkg.sv
// Shared constants and state encoding for the NLM denoise pipeline
// (PE chain widths, normalisation divider iteration count and FSM states).
package nlm_pkg;

    localparam int DATA_WIDTH       = 16;
    localparam int PIX_SUM_WIDTH    = 32;
    localparam int WEIGHT_SUM_WIDTH = 32;

    // The rounded dividend carries one extra bit, so the divider walks every one of them.
    localparam int DIV_ITERS = PIX_SUM_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } nlm_div_state_t;

endpackage

// File: rtl/nlm_norm_div_if.sv
// Input (sum pair) and output (pixel) handshakes of the normalisation stage.
interface nlm_norm_div_if;
    import nlm_pkg::*;

    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [PIX_SUM_WIDTH-1:0]    pix_sum_i;
    logic [WEIGHT_SUM_WIDTH-1:0] weight_sum_i;
    logic [DATA_WIDTH-1:0]       center_pix_i;
    logic                        out_valid_o;
    logic                        out_ready_i;
    logic [DATA_WIDTH-1:0]       pix_o;
    logic                        div0_o;
    logic                        sat_o;

    modport master (
        output in_valid_i, pix_sum_i, weight_sum_i, center_pix_i, out_ready_i,
        input  in_ready_o, out_valid_o, pix_o, div0_o, sat_o
    );

    modport slave (
        input  in_valid_i, pix_sum_i, weight_sum_i, center_pix_i, out_ready_i,
        output in_ready_o, out_valid_o, pix_o, div0_o, sat_o
    );

endinterface

// File: rtl/nlm_div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module nlm_div_step
    import nlm_pkg::*;
#(
    parameter int DIVISOR_W = WEIGHT_SUM_WIDTH
) (
    input  logic [DIVISOR_W:0]   i_rem,
    input  logic                 i_dividendBit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W:0]   o_rem,
    output logic                 o_quotBit
);

    logic [DIVISOR_W:0] w_shifted;
    logic [DIVISOR_W:0] w_diff;

    assign w_shifted = {i_rem[DIVISOR_W-1:0], i_dividendBit};
    assign w_diff    = w_shifted - {1'b0, i_divisor};

    // A set remainder MSB means the shifted value overflowed the window and certainly exceeds the divisor.
    assign o_quotBit = i_rem[DIVISOR_W] | (w_shifted >= {1'b0, i_divisor});
    assign o_rem     = o_quotBit ? w_diff : w_shifted;

endmodule

// File: rtl/nlm_norm_div.sv
// NLM normalisation: round(pix_sum / weight_sum) by an iterative restoring
// divider, with zero-weight fallback to the centre pixel and output saturation.
module nlm_norm_div
    import nlm_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    nlm_norm_div_if.slave bus
);

    localparam int REM_W = WEIGHT_SUM_WIDTH + 1;
    localparam int CNT_W = $clog2(DIV_ITERS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_ITERS - 1);

    nlm_div_state_t              r_state;
    logic [DIV_ITERS-1:0]        r_dividend;
    logic [WEIGHT_SUM_WIDTH-1:0] r_divisor;
    logic [REM_W-1:0]            r_rem;
    logic [DIV_ITERS-1:0]        r_quot;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_outValid;
    logic [DATA_WIDTH-1:0]       r_pix;
    logic                        r_div0;
    logic                        r_sat;

    logic [DIV_ITERS-1:0]        w_dividendRounded;
    logic [REM_W-1:0]            w_remNext;
    logic                        w_quotBit;
    logic [DIV_ITERS-1:0]        w_quotNext;
    logic                        w_quotOverflow;

    // Pre-adding half the divisor turns the truncating divide into round-half-up; the extra bit prevents wrap.
    assign w_dividendRounded = {1'b0, bus.pix_sum_i} + DIV_ITERS'(bus.weight_sum_i >> 1);

    nlm_div_step #(
        .DIVISOR_W (WEIGHT_SUM_WIDTH)
    ) u_step (
        .i_rem         (r_rem),
        .i_dividendBit (r_dividend[DIV_ITERS-1]),
        .i_divisor     (r_divisor),
        .o_rem         (w_remNext),
        .o_quotBit     (w_quotBit)
    );

    assign w_quotNext     = {r_quot[DIV_ITERS-2:0], w_quotBit};
    assign w_quotOverflow = |w_quotNext[DIV_ITERS-1:DATA_WIDTH];

    // DONE is entered one cycle early on the zero-weight path; out_valid follows a cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_outValid <= 1'b0;
            r_pix      <= '0;
            r_div0     <= 1'b0;
            r_sat      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid_i) begin
                        if (bus.weight_sum_i != '0) begin
                            r_dividend <= w_dividendRounded;
                            r_divisor  <= bus.weight_sum_i;
                            r_rem      <= '0;
                            r_quot     <= '0;
                            r_cnt      <= '0;
                            r_state    <= DIV;
                        end else begin
                            r_pix   <= bus.center_pix_i;
                            r_div0  <= 1'b1;
                            r_sat   <= 1'b0;
                            r_state <= DONE;
                        end
                    end
                end
                DIV: begin
                    r_dividend <= r_dividend << 1;
                    r_rem      <= w_remNext;
                    r_quot     <= w_quotNext;
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == LAST_STEP) begin
                        r_state    <= DONE;
                        r_outValid <= 1'b1;
                        r_div0     <= 1'b0;
                        if (w_quotOverflow) begin
                            r_pix <= '1;
                            r_sat <= 1'b1;
                        end else begin
                            r_pix <= w_quotNext[DATA_WIDTH-1:0];
                            r_sat <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (!r_outValid) begin
                        r_outValid <= 1'b1;
                    end else if (bus.out_ready_i) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = (r_state == IDLE) && rst_n;
    assign bus.out_valid_o = r_outValid;
    assign bus.pix_o       = r_pix;
    assign bus.div0_o      = r_div0;
    assign bus.sat_o       = r_sat;

endmodule

// File: tb/tb_nlm_norm_div.sv
// Directed self-checking bench for nlm_norm_div: rounding, zero weight,
// saturation, backpressure and mid-operation reset.
module tb_nlm_norm_div;
    import nlm_pkg::*;

    localparam int MAX_WAIT = 200;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    nlm_norm_div_if bus ();

    nlm_norm_div dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one sum pair and return just after the edge that accepted it.
    task automatic applyStimulus(input logic [31:0] pixSum, input logic [31:0] weightSum,
                                 input logic [15:0] centerPix);
        int n;
        n = 0;
        while (bus.in_ready_o !== 1'b1 && n < MAX_WAIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= MAX_WAIT) checkOutput("in_ready_timeout", 64'(bus.in_ready_o), 64'd1);
        bus.in_valid_i   = 1'b1;
        bus.pix_sum_i    = pixSum;
        bus.weight_sum_i = weightSum;
        bus.center_pix_i = centerPix;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic waitValid(output int latency);
        latency = 0;
        do begin
            @(posedge clk);
            #1;
            latency++;
        end while (bus.out_valid_o !== 1'b1 && latency < MAX_WAIT);
    endtask

    // Full transaction with out_ready held high: latency, result, flags and return to IDLE.
    task automatic runOp(input string tag, input logic [31:0] pixSum, input logic [31:0] weightSum,
                         input logic [15:0] centerPix, input int expLatency,
                         input logic [15:0] expPix, input logic expDiv0, input logic expSat);
        int latency;
        applyStimulus(pixSum, weightSum, centerPix);
        waitValid(latency);
        checkOutput({tag, "_latency"}, 64'(latency), 64'(expLatency));
        checkOutput({tag, "_pix"}, 64'(bus.pix_o), 64'(expPix));
        checkOutput({tag, "_div0"}, 64'(bus.div0_o), 64'(expDiv0));
        checkOutput({tag, "_sat"}, 64'(bus.sat_o), 64'(expSat));
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid_drop"}, 64'(bus.out_valid_o), 64'd0);
        checkOutput({tag, "_ready_back"}, 64'(bus.in_ready_o), 64'd1);
    endtask

    initial begin
        int latency;
        int sawValid;
        errors = 0;
        checks = 0;
        rst_n            = 1'b0;
        bus.in_valid_i   = 1'b0;
        bus.pix_sum_i    = '0;
        bus.weight_sum_i = '0;
        bus.center_pix_i = '0;
        bus.out_ready_i  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
        checkOutput("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        checkOutput("rst_pix", 64'(bus.pix_o), 64'd0);
        checkOutput("rst_div0", 64'(bus.div0_o), 64'd0);
        checkOutput("rst_sat", 64'(bus.sat_o), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("idle_in_ready", 64'(bus.in_ready_o), 64'd1);

        $display("[TB] basic, rounding and boundary divisions");
        runOp("div1000_10", 32'd1000, 32'd10, 16'h0000, 33, 16'd100, 1'b0, 1'b0);
        runOp("round7_2", 32'd7, 32'd2, 16'h0000, 33, 16'd4, 1'b0, 1'b0);
        runOp("round5_3", 32'd5, 32'd3, 16'h0000, 33, 16'd2, 1'b0, 1'b0);
        runOp("zero_w", 32'd5555, 32'd0, 16'h0123, 1, 16'h0123, 1'b1, 1'b0);
        runOp("sat_w1", 32'hFFFF_FFFF, 32'd1, 16'h0000, 33, 16'hFFFF, 1'b0, 1'b1);
        runOp("nowrap_w3", 32'hFFFF_FFFF, 32'd3, 16'h0000, 33, 16'hFFFF, 1'b0, 1'b1);
        runOp("max_nosat", 32'd262140, 32'd4, 16'h0000, 33, 16'hFFFF, 1'b0, 1'b0);
        runOp("just_sat", 32'd262142, 32'd4, 16'h0000, 33, 16'hFFFF, 1'b0, 1'b1);
        runOp("zero_pix", 32'd0, 32'd9, 16'h0000, 33, 16'd0, 1'b0, 1'b0);

        $display("[TB] backpressure in DONE");
        bus.out_ready_i = 1'b0;
        applyStimulus(32'd300, 32'd7, 16'h0000);
        waitValid(latency);
        checkOutput("bp_latency", 64'(latency), 64'd33);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                bus.in_valid_i   = 1'b1;
                bus.weight_sum_i = 32'd0;
                bus.center_pix_i = 16'hBEEF;
            end
            @(posedge clk);
            #1;
            bus.in_valid_i = 1'b0;
            checkOutput("bp_valid", 64'(bus.out_valid_o), 64'd1);
            checkOutput("bp_in_ready", 64'(bus.in_ready_o), 64'd0);
            checkOutput("bp_pix", 64'(bus.pix_o), 64'd43);
            checkOutput("bp_div0", 64'(bus.div0_o), 64'd0);
            checkOutput("bp_sat", 64'(bus.sat_o), 64'd0);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_valid", 64'(bus.out_valid_o), 64'd0);
        checkOutput("bp_release_ready", 64'(bus.in_ready_o), 64'd1);
        checkOutput("bp_release_pix", 64'(bus.pix_o), 64'd43);

        $display("[TB] reset during division");
        applyStimulus(32'd1000, 32'd10, 16'h0000);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_valid", 64'(bus.out_valid_o), 64'd0);
        checkOutput("midrst_pix", 64'(bus.pix_o), 64'd0);
        checkOutput("midrst_sat", 64'(bus.sat_o), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_idle", 64'(bus.in_ready_o), 64'd1);
        sawValid = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid_o !== 1'b0) sawValid = 1;
        end
        checkOutput("midrst_no_result", 64'(sawValid), 64'd0);
        runOp("after_rst", 32'd1000, 32'd10, 16'h0000, 33, 16'd100, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
